// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types for the result scoreboard
//
// Contents:
//   SB_MAX_DATA_W - storage width of an entry's data/mask fields (DATA_W must not exceed it)
//   sb_state_e    - scoreboard FSM states
//   sb_entry_t    - one expected-table entry: valid flag, data, mask (SCOREBOARD_MASK_EN only)
package scoreboard_pkg;

    localparam int SB_MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_RUN   = 2'd1,
        SB_DRAIN = 2'd2,
        SB_DONE  = 2'd3
    } sb_state_e;

    // Data and mask are zero-extended to SB_MAX_DATA_W so one struct serves
    // every DATA_W; the unused upper bits are zero on both compare operands.
    typedef struct packed {
        logic                     valid;
        logic [SB_MAX_DATA_W-1:0] data;
`ifdef SCOREBOARD_MASK_EN
        logic [SB_MAX_DATA_W-1:0] mask;
`endif
    } sb_entry_t;

endpackage

// File: rtl/sb_table.sv
// rtl/sb_table.sv - expected-result table, one write port, one asynchronous read port
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable (already qualified by the caller)
//   waddr_i  in   write entry index
//   wvalid_i in   expected valid flag to store
//   wdata_i  in   expected data to store
//   wmask_i  in   per-bit compare mask to store (SCOREBOARD_MASK_EN only)
//   raddr_i  in   read entry index
//   rdata_o  out  entry at raddr_i, combinational
//
// The storage has no reset: contents survive n_reset.
module sb_table
    import scoreboard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic                     wvalid_i,
    input  logic [DATA_W-1:0]        wdata_i,
`ifdef SCOREBOARD_MASK_EN
    input  logic [DATA_W-1:0]        wmask_i,
`endif
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output sb_entry_t                rdata_o
);

    sb_entry_t mem_q [DEPTH];
    sb_entry_t wr_entry;

    always_comb begin
        wr_entry       = '0;
        wr_entry.valid = wvalid_i;
        wr_entry.data  = SB_MAX_DATA_W'(wdata_i);
`ifdef SCOREBOARD_MASK_EN
        wr_entry.mask  = SB_MAX_DATA_W'(wmask_i);
`endif
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wr_entry;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_scoreboard.sv
// rtl/result_scoreboard.sv - compares a DUT result stream against an expected table
//
// Ports:
//   clk, n_reset                      clock, synchronous active-low reset
//   start_i                           one-cycle run start (IDLE/DONE only)
//   exp_we_i/exp_addr_i/exp_valid_i/exp_data_i  expected-table write port
//   exp_mask_i                        per-entry compare mask (SCOREBOARD_MASK_EN only)
//   obs_valid_i/obs_data_i            observed result, sampled each RUN/DRAIN cycle
//   stop_i                            DUT stop indication (acted on in RUN only)
//   done_o/pass_o/overrun_o           run finished / zero failures / table exhausted
//   check_cnt_o/fail_cnt_o            checks performed / checks failed
//   first_fail_vld_o/first_fail_idx_o first failing sample captured / its index
//
// Build option: define SCOREBOARD_MASK_EN to add a per-entry data mask.
module result_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int STOP_LAT = 3
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     start_i,
    input  logic                     exp_we_i,
    input  logic [$clog2(DEPTH)-1:0] exp_addr_i,
    input  logic                     exp_valid_i,
    input  logic [DATA_W-1:0]        exp_data_i,
`ifdef SCOREBOARD_MASK_EN
    input  logic [DATA_W-1:0]        exp_mask_i,
`endif
    input  logic                     obs_valid_i,
    input  logic [DATA_W-1:0]        obs_data_i,
    input  logic                     stop_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     overrun_o,
    output logic [$clog2(DEPTH)+1:0] check_cnt_o,
    output logic [$clog2(DEPTH)+1:0] fail_cnt_o,
    output logic                     first_fail_vld_o,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 2;
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [3:0]    LAT_LAST = 4'(STOP_LAT);

    sb_state_e   state_q;
    logic [AW-1:0] idx_q;
    logic [3:0]  drain_cnt_q;
    logic [CW-1:0] check_cnt_q;
    logic [CW-1:0] fail_cnt_q;
    logic        ff_vld_q;
    logic [AW-1:0] ff_idx_q;
    logic        overrun_q;
    logic        done_q;
    logic        pass_q;

    sb_entry_t   rd_entry;
    logic        tbl_we;
    logic        valid_fail;
    logic        data_fail;
    logic        sample_fail;
    logic        sample_is_drain;
    logic        drain_end;
    logic [3:0]  drain_cnt_d;
    logic [CW-1:0] check_cnt_d;
    logic [CW-1:0] fail_cnt_d;

    // The table is frozen while a run is comparing against it.
    assign tbl_we = exp_we_i && ((state_q == SB_IDLE) || (state_q == SB_DONE));

    sb_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk      (clk),
        .we_i     (tbl_we),
        .waddr_i  (exp_addr_i),
        .wvalid_i (exp_valid_i),
        .wdata_i  (exp_data_i),
`ifdef SCOREBOARD_MASK_EN
        .wmask_i  (exp_mask_i),
`endif
        .raddr_i  (idx_q),
        .rdata_o  (rd_entry)
    );

    always_comb begin
        valid_fail = (obs_valid_i != rd_entry.valid);
`ifdef SCOREBOARD_MASK_EN
        data_fail  = ((SB_MAX_DATA_W'(obs_data_i) ^ rd_entry.data) & rd_entry.mask) != '0;
`else
        data_fail  = (SB_MAX_DATA_W'(obs_data_i) != rd_entry.data);
`endif
        sample_fail = valid_fail | data_fail;
        check_cnt_d = check_cnt_q + CW'(2);
        fail_cnt_d  = fail_cnt_q + CW'(valid_fail) + CW'(data_fail);

        // The cycle stop_i is first seen in RUN is itself drain sample 1.
        sample_is_drain = (state_q == SB_DRAIN) || ((state_q == SB_RUN) && stop_i);
        drain_cnt_d     = (state_q == SB_RUN) ? 4'd1 : drain_cnt_q + 4'd1;
        drain_end       = sample_is_drain && (drain_cnt_d == LAT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= SB_IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            check_cnt_q <= '0;
            fail_cnt_q  <= '0;
            ff_vld_q    <= 1'b0;
            ff_idx_q    <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                SB_IDLE, SB_DONE: begin
                    if (start_i) begin
                        state_q     <= SB_RUN;
                        idx_q       <= '0;
                        drain_cnt_q <= '0;
                        check_cnt_q <= '0;
                        fail_cnt_q  <= '0;
                        ff_vld_q    <= 1'b0;
                        ff_idx_q    <= '0;
                        overrun_q   <= 1'b0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                SB_RUN, SB_DRAIN: begin
                    check_cnt_q <= check_cnt_d;
                    fail_cnt_q  <= fail_cnt_d;
                    if (sample_fail && !ff_vld_q) begin
                        ff_vld_q <= 1'b1;
                        ff_idx_q <= idx_q;
                    end
                    if (sample_is_drain) begin
                        drain_cnt_q <= drain_cnt_d;
                    end
                    // A drain that finishes exactly on the last entry is not an overrun.
                    if (drain_end) begin
                        state_q <= SB_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_cnt_d == '0);
                    end else if (idx_q == IDX_LAST) begin
                        state_q   <= SB_DONE;
                        overrun_q <= 1'b1;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                        if (sample_is_drain) begin
                            state_q <= SB_DRAIN;
                        end
                    end
                end
                default: begin
                    state_q <= SB_IDLE;
                end
            endcase
        end
    end

    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign overrun_o        = overrun_q;
    assign check_cnt_o      = check_cnt_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign first_fail_vld_o = ff_vld_q;
    assign first_fail_idx_o = ff_idx_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// tb/tb_result_scoreboard.sv - directed self-checking bench for result_scoreboard
module tb_result_scoreboard;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start_i;
    logic        exp_we_i;
    logic [2:0]  exp_addr_i;
    logic        exp_valid_i;
    logic [31:0] exp_data_i;
`ifdef SCOREBOARD_MASK_EN
    logic [31:0] exp_mask_i;
`endif
    logic        obs_valid_i;
    logic [31:0] obs_data_i;
    logic        stop_i;
    logic        done_o;
    logic        pass_o;
    logic        overrun_o;
    logic [4:0]  check_cnt_o;
    logic [4:0]  fail_cnt_o;
    logic        first_fail_vld_o;
    logic [2:0]  first_fail_idx_o;

    int checks = 0;
    int errors = 0;

    logic        tbl_v [8];
    logic [31:0] tbl_d [8];
    logic        obs_v [8];
    logic [31:0] obs_d [8];

    always #5 clk = ~clk;

    result_scoreboard #(.DATA_W(32), .DEPTH(8), .STOP_LAT(3)) dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .start_i          (start_i),
        .exp_we_i         (exp_we_i),
        .exp_addr_i       (exp_addr_i),
        .exp_valid_i      (exp_valid_i),
        .exp_data_i       (exp_data_i),
`ifdef SCOREBOARD_MASK_EN
        .exp_mask_i       (exp_mask_i),
`endif
        .obs_valid_i      (obs_valid_i),
        .obs_data_i       (obs_data_i),
        .stop_i           (stop_i),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .overrun_o        (overrun_o),
        .check_cnt_o      (check_cnt_o),
        .fail_cnt_o       (fail_cnt_o),
        .first_fail_vld_o (first_fail_vld_o),
        .first_fail_idx_o (first_fail_idx_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_match();
        for (int i = 0; i < 8; i++) begin
            obs_v[i] = tbl_v[i];
            obs_d[i] = tbl_d[i];
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            exp_we_i    = 1'b1;
            exp_addr_i  = 3'(i);
            exp_valid_i = tbl_v[i];
            exp_data_i  = tbl_d[i];
`ifdef SCOREBOARD_MASK_EN
            exp_mask_i  = 32'hFFFF_FFFF;
`endif
            tick();
        end
        exp_we_i = 1'b0;
    endtask

    // Starts a run and feeds obs_v/obs_d; stop_i on sample stop_at, and on
    // sample glitch_at a stray start_i plus table write that must be ignored.
    task automatic run_stream(input int stop_at, input int glitch_at);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 20 && !done_o; k++) begin
            obs_valid_i = (k < 8) ? obs_v[k] : 1'b0;
            obs_data_i  = (k < 8) ? obs_d[k] : 32'h0;
            stop_i      = (k == stop_at);
            start_i     = (k == glitch_at);
            exp_we_i    = (k == glitch_at);
            exp_addr_i  = 3'd0;
            exp_valid_i = 1'b0;
            exp_data_i  = 32'h55;
            tick();
        end
        stop_i = 1'b0; start_i = 1'b0; exp_we_i = 1'b0;
        obs_valid_i = 1'b0; obs_data_i = 32'h0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout: done_o=%b required 1", done_o);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        tick(); tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        checks++; if (check_cnt_o !== 5'd0) begin errors++; $display("FAIL reset_check_cnt: got %0d want 0", check_cnt_o); end
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt_o); end
        checks++; if (first_fail_vld_o !== 1'b0) begin errors++; $display("FAIL reset_ff_vld: got %b want 0", first_fail_vld_o); end
        checks++; if (first_fail_idx_o !== 3'd0) begin errors++; $display("FAIL reset_ff_idx: got %0d want 0", first_fail_idx_o); end
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_clean_run();
        set_match();
        run_stream(5, -1);
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL clean_check_cnt: got %0d want 16", check_cnt_o); end
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL clean_fail_cnt: got %0d want 0", fail_cnt_o); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL clean_pass: got %b want 1", pass_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL clean_overrun: got %b want 0", overrun_o); end
        checks++; if (first_fail_vld_o !== 1'b0) begin errors++; $display("FAIL clean_ff_vld: got %b want 0", first_fail_vld_o); end
    endtask

    task automatic test_single_fail();
        set_match();
        obs_d[2] = 32'd9;
        run_stream(5, -1);
        checks++; if (fail_cnt_o !== 5'd1) begin errors++; $display("FAIL single_fail_cnt: got %0d want 1", fail_cnt_o); end
        checks++; if (first_fail_idx_o !== 3'd2) begin errors++; $display("FAIL single_ff_idx: got %0d want 2", first_fail_idx_o); end
        checks++; if (first_fail_vld_o !== 1'b1) begin errors++; $display("FAIL single_ff_vld: got %b want 1", first_fail_vld_o); end
        checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL single_pass: got %b want 0", pass_o); end
    endtask

    task automatic test_multi_fail();
        set_match();
        obs_v[4] = 1'b0;
        obs_d[4] = 32'd4;
        obs_d[6] = 32'd6;
        run_stream(5, -1);
        checks++; if (fail_cnt_o !== 5'd3) begin errors++; $display("FAIL multi_fail_cnt: got %0d want 3", fail_cnt_o); end
        checks++; if (first_fail_idx_o !== 3'd4) begin errors++; $display("FAIL multi_ff_idx: got %0d want 4", first_fail_idx_o); end
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL multi_check_cnt: got %0d want 16", check_cnt_o); end
    endtask

    task automatic test_overrun();
        set_match();
        run_stream(-1, -1);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_overrun: got %b want 1", overrun_o); end
        checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL ovr_pass: got %b want 0", pass_o); end
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL ovr_check_cnt: got %0d want 16", check_cnt_o); end
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL ovr_fail_cnt: got %0d want 0", fail_cnt_o); end
        // stop on the last entry leaves the drain short of the table
        run_stream(7, -1);
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL late_stop_overrun: got %b want 1", overrun_o); end
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL late_stop_check_cnt: got %0d want 16", check_cnt_o); end
    endtask

    task automatic test_early_stop();
        set_match();
        run_stream(0, -1);
        checks++; if (check_cnt_o !== 5'd6) begin errors++; $display("FAIL early_stop_check_cnt: got %0d want 6", check_cnt_o); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL early_stop_pass: got %b want 1", pass_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL early_stop_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_back_to_back();
        set_match();
        // from DONE with overrun set; stray start/write mid-run must be ignored
        run_stream(-1, -1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %b want 0", done_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear: got %b want 0", overrun_o); end
        n_reset = 1'b0; tick(); n_reset = 1'b1;
        run_stream(5, 2);
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL ignored_start_check_cnt: got %0d want 16", check_cnt_o); end
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL ignored_start_pass: got %b want 1", pass_o); end
        run_stream(5, -1);
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL ignored_write_pass: got %b want 1", pass_o); end
    endtask

    task automatic test_reset_midrun();
        set_match();
        obs_d[1] = 32'h0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs_valid_i = obs_v[k];
            obs_data_i  = obs_d[k];
            tick();
            if (k == 0) begin
                checks++; if (check_cnt_o !== 5'd2) begin errors++; $display("FAIL latency_check_cnt: got %0d want 2", check_cnt_o); end
                checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL latency_fail_cnt: got %0d want 0", fail_cnt_o); end
            end
            if (k == 1) begin
                checks++; if (fail_cnt_o !== 5'd1) begin errors++; $display("FAIL latency_fail_inc: got %0d want 1", fail_cnt_o); end
                checks++; if (first_fail_idx_o !== 3'd1) begin errors++; $display("FAIL latency_ff_idx: got %0d want 1", first_fail_idx_o); end
            end
        end
        n_reset = 1'b0;
        obs_valid_i = obs_v[3];
        obs_data_i  = obs_d[3];
        tick();
        checks++; if (check_cnt_o !== 5'd0) begin errors++; $display("FAIL midrst_check_cnt: got %0d want 0", check_cnt_o); end
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL midrst_fail_cnt: got %0d want 0", fail_cnt_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done_o); end
        n_reset = 1'b1;
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", done_o); end
        set_match();
        run_stream(5, -1);
        checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL midrst_rerun_pass: got %b want 1", pass_o); end
        checks++; if (check_cnt_o !== 5'd16) begin errors++; $display("FAIL midrst_rerun_check_cnt: got %0d want 16", check_cnt_o); end
    endtask

`ifdef SCOREBOARD_MASK_EN
    task automatic test_mask();
        exp_we_i = 1'b1; exp_addr_i = 3'd1; exp_valid_i = 1'b1;
        exp_data_i = 32'hFFFF_FFFE; exp_mask_i = 32'h0000_FFFF;
        tick();
        exp_we_i = 1'b0;
        set_match();
        obs_d[1] = 32'hFFFF_0000 | 32'h0000_FFFE;
        run_stream(5, -1);
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL mask_spec_fail_cnt: got %0d want 0", fail_cnt_o); end
        obs_d[1] = 32'h1234_FFFE;
        run_stream(5, -1);
        checks++; if (fail_cnt_o !== 5'd0) begin errors++; $display("FAIL mask_hi_ignored: got %0d want 0", fail_cnt_o); end
        obs_d[1] = 32'hFFFF_FFFF;
        run_stream(5, -1);
        checks++; if (fail_cnt_o !== 5'd1) begin errors++; $display("FAIL mask_lo_checked: got %0d want 1", fail_cnt_o); end
        checks++; if (first_fail_idx_o !== 3'd1) begin errors++; $display("FAIL mask_ff_idx: got %0d want 1", first_fail_idx_o); end
    endtask
`endif

    initial begin
        n_reset = 1'b1; start_i = 1'b0; exp_we_i = 1'b0; exp_addr_i = 3'd0;
        exp_valid_i = 1'b0; exp_data_i = 32'h0; obs_valid_i = 1'b0;
        obs_data_i = 32'h0; stop_i = 1'b0;
`ifdef SCOREBOARD_MASK_EN
        exp_mask_i = 32'hFFFF_FFFF;
`endif
        tbl_v[0] = 1'b1; tbl_d[0] = 32'h8;
        tbl_v[1] = 1'b1; tbl_d[1] = 32'hFFFF_FFFE;
        tbl_v[2] = 1'b1; tbl_d[2] = 32'h8;
        tbl_v[3] = 1'b0; tbl_d[3] = 32'h0;
        tbl_v[4] = 1'b1; tbl_d[4] = 32'h3;
        tbl_v[5] = 1'b1; tbl_d[5] = 32'hFFFF_FFFF;
        tbl_v[6] = 1'b1; tbl_d[6] = 32'h7;
        tbl_v[7] = 1'b0; tbl_d[7] = 32'h0;

        test_reset();
        load_table();
        test_clean_run();
        test_single_fail();
        test_multi_fail();
        test_overrun();
        test_early_stop();
        test_back_to_back();
        test_reset_midrun();
`ifdef SCOREBOARD_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
